// File: rtl/y_phase_sequencer.sv
// Phase sequencer that grants the shared Y SRAM bus to compute, write and integrate
// in turn, with idle turnaround gaps, iteration counting and per-phase timeouts.
module y_phase_sequencer #(
    parameter int ITER_W      = 8,
    parameter int GAP_CYC     = 1,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_start,
    input  logic [ITER_W-1:0] in_iterLimit,
    input  logic              in_computeDone,
    input  logic              in_writeDone,
    input  logic              in_integrateDone,
    input  logic              in_converged,
    output logic              op_yComputeModuleEnable,
    output logic              op_yWriteModuleEnable,
    output logic              op_integrateModEnable,
    output logic              op_busy,
    output logic              op_done,
    output logic [ITER_W-1:0] op_iterCount,
    output logic              op_timeout
);

    localparam int WAIT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYC - 1);
    localparam logic [3:0] GAP_LAST = 4'(GAP_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        COMPUTE,
        WRITE,
        INTEGRATE,
        GAP,
        FINISH
    } seqState_t;

    seqState_t         state, stateNxt;
    seqState_t         nextPhase, nextPhaseNxt;
    logic [3:0]        gapCnt, gapCntNxt;
    logic [WAIT_W-1:0] waitCnt, waitCntNxt;
    logic [ITER_W-1:0] iterLimit, iterLimitNxt;
    logic [ITER_W-1:0] iterCountNxt;
    logic [ITER_W-1:0] iterCountInc;
    logic              timeoutNxt;
    logic              waitExpired;

    function automatic logic [ITER_W-1:0] satInc(input logic [ITER_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign iterCountInc = satInc(op_iterCount);
    assign waitExpired  = (waitCnt == WAIT_LAST);

    always_comb begin
        stateNxt     = state;
        nextPhaseNxt = nextPhase;
        gapCntNxt    = gapCnt;
        waitCntNxt   = waitCnt + 1'b1;
        iterLimitNxt = iterLimit;
        iterCountNxt = op_iterCount;
        timeoutNxt   = op_timeout;
        case (state)
            IDLE: begin
                waitCntNxt = '0;
                if (in_start) begin
                    iterLimitNxt = (in_iterLimit == '0) ? ITER_W'(1) : in_iterLimit;
                    iterCountNxt = '0;
                    timeoutNxt   = 1'b0;
                    stateNxt     = COMPUTE;
                end
            end
            COMPUTE: begin
                if (in_computeDone) begin
                    stateNxt     = GAP;
                    nextPhaseNxt = WRITE;
                    gapCntNxt    = '0;
                    waitCntNxt   = '0;
                end else if (waitExpired) begin
                    stateNxt   = IDLE;
                    timeoutNxt = 1'b1;
                    waitCntNxt = '0;
                end
            end
            WRITE: begin
                if (in_writeDone) begin
                    stateNxt     = GAP;
                    nextPhaseNxt = INTEGRATE;
                    gapCntNxt    = '0;
                    waitCntNxt   = '0;
                end else if (waitExpired) begin
                    stateNxt   = IDLE;
                    timeoutNxt = 1'b1;
                    waitCntNxt = '0;
                end
            end
            INTEGRATE: begin
                // Convergence is only meaningful alongside the integrate handshake.
                if (in_integrateDone) begin
                    iterCountNxt = iterCountInc;
                    waitCntNxt   = '0;
                    if (in_converged || (iterCountInc == iterLimit)) begin
                        stateNxt = FINISH;
                    end else begin
                        stateNxt     = GAP;
                        nextPhaseNxt = COMPUTE;
                        gapCntNxt    = '0;
                    end
                end else if (waitExpired) begin
                    stateNxt   = IDLE;
                    timeoutNxt = 1'b1;
                    waitCntNxt = '0;
                end
            end
            GAP: begin
                waitCntNxt = '0;
                if (gapCnt == GAP_LAST) begin
                    stateNxt  = nextPhase;
                    gapCntNxt = '0;
                end else begin
                    gapCntNxt = gapCnt + 1'b1;
                end
            end
            FINISH: begin
                waitCntNxt = '0;
                stateNxt   = IDLE;
            end
            default: begin
                waitCntNxt = '0;
                stateNxt   = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so every flag is a flop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state                   <= IDLE;
            nextPhase               <= IDLE;
            gapCnt                  <= '0;
            waitCnt                 <= '0;
            iterLimit               <= '0;
            op_iterCount            <= '0;
            op_timeout              <= 1'b0;
            op_yComputeModuleEnable <= 1'b0;
            op_yWriteModuleEnable   <= 1'b0;
            op_integrateModEnable   <= 1'b0;
            op_busy                 <= 1'b0;
            op_done                 <= 1'b0;
        end else begin
            state                   <= stateNxt;
            nextPhase               <= nextPhaseNxt;
            gapCnt                  <= gapCntNxt;
            waitCnt                 <= waitCntNxt;
            iterLimit               <= iterLimitNxt;
            op_iterCount            <= iterCountNxt;
            op_timeout              <= timeoutNxt;
            op_yComputeModuleEnable <= (stateNxt == COMPUTE);
            op_yWriteModuleEnable   <= (stateNxt == WRITE);
            op_integrateModEnable   <= (stateNxt == INTEGRATE);
            op_busy                 <= (stateNxt != IDLE);
            op_done                 <= (stateNxt == FINISH);
        end
    end

endmodule

// File: tb/tb_y_phase_sequencer.sv
// Directed bench for y_phase_sequencer: iteration runs, convergence, ignored inputs,
// phase timeout, async reset mid-phase, plus a per-cycle enable exclusivity checker.
module tb_y_phase_sequencer;

    localparam int ITER_W = 8;

    logic              clk;
    logic              reset;
    logic              in_start;
    logic [ITER_W-1:0] in_iterLimit;
    logic              in_computeDone;
    logic              in_writeDone;
    logic              in_integrateDone;
    logic              in_converged;
    logic              op_yComputeModuleEnable;
    logic              op_yWriteModuleEnable;
    logic              op_integrateModEnable;
    logic              op_busy;
    logic              op_done;
    logic [ITER_W-1:0] op_iterCount;
    logic              op_timeout;
    logic [2:0]        en;

    int tests  = 0;
    int failed = 0;

    y_phase_sequencer #(
        .ITER_W     (ITER_W),
        .GAP_CYC    (1),
        .TIMEOUT_CYC(16)
    ) dut (
        .clk                    (clk),
        .reset                  (reset),
        .in_start               (in_start),
        .in_iterLimit           (in_iterLimit),
        .in_computeDone         (in_computeDone),
        .in_writeDone           (in_writeDone),
        .in_integrateDone       (in_integrateDone),
        .in_converged           (in_converged),
        .op_yComputeModuleEnable(op_yComputeModuleEnable),
        .op_yWriteModuleEnable  (op_yWriteModuleEnable),
        .op_integrateModEnable  (op_integrateModEnable),
        .op_busy                (op_busy),
        .op_done                (op_done),
        .op_iterCount           (op_iterCount),
        .op_timeout             (op_timeout)
    );

    assign en = {op_yComputeModuleEnable, op_yWriteModuleEnable, op_integrateModEnable};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Enables never overlap, and are low whenever idle or finishing.
    always @(negedge clk) begin
        tests++;
        assert ($onehot0(en) && !(op_done && en != 3'b000) && !(!op_busy && en != 3'b000))
        else begin
            failed++;
            $error("FAIL enableExclusive: observed en=%b busy=%b done=%b expected onehot0/low", en, op_busy, op_done);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic startRun(input logic [ITER_W-1:0] limit);
        in_start     = 1'b1;
        in_iterLimit = limit;
        tick();
        in_start     = 1'b0;
        in_iterLimit = 8'd99;
    endtask

    // Hold the expected enable for 'hold' observations, returning done on the last.
    task automatic phase(input string tag, input logic [2:0] expEn, input int hold, input logic conv);
        for (int i = 0; i < hold; i++) begin
            chk(tag, 32'(en), 32'(expEn));
            if (i == hold - 1) begin
                in_computeDone   = expEn[2];
                in_writeDone     = expEn[1];
                in_integrateDone = expEn[0];
                in_converged     = conv;
            end
            tick();
        end
        in_computeDone   = 1'b0;
        in_writeDone     = 1'b0;
        in_integrateDone = 1'b0;
        in_converged     = 1'b0;
    endtask

    task automatic gap(input string tag);
        chk(tag, 32'(en), 32'd0);
        chk({tag, "Busy"}, 32'(op_busy), 32'd1);
        tick();
    endtask

    initial begin
        reset            = 1'b0;
        in_start         = 1'b0;
        in_iterLimit     = '0;
        in_computeDone   = 1'b0;
        in_writeDone     = 1'b0;
        in_integrateDone = 1'b0;
        in_converged     = 1'b0;
        tick();
        tick();
        chk("rstEn", 32'(en), 32'd0);
        chk("rstBusy", 32'(op_busy), 32'd0);
        chk("rstDone", 32'(op_done), 32'd0);
        chk("rstIter", 32'(op_iterCount), 32'd0);
        chk("rstTimeout", 32'(op_timeout), 32'd0);
        reset = 1'b1;
        tick();
        tick();
        chk("idleEn", 32'(en), 32'd0);
        chk("idleBusy", 32'(op_busy), 32'd0);

        // Two full iterations, limit 2
        startRun(8'd2);
        phase("r1C1", 3'b100, 3, 1'b0);
        gap("r1G1");
        phase("r1W1", 3'b010, 3, 1'b0);
        gap("r1G2");
        phase("r1I1", 3'b001, 3, 1'b0);
        chk("r1Iter1", 32'(op_iterCount), 32'd1);
        gap("r1G3");
        phase("r1C2", 3'b100, 3, 1'b0);
        gap("r1G4");
        phase("r1W2", 3'b010, 3, 1'b0);
        gap("r1G5");
        phase("r1I2", 3'b001, 3, 1'b0);
        chk("r1FinEn", 32'(en), 32'd0);
        chk("r1Done", 32'(op_done), 32'd1);
        chk("r1Iter", 32'(op_iterCount), 32'd2);
        tick();
        chk("r1DoneFall", 32'(op_done), 32'd0);
        chk("r1Idle", 32'(op_busy), 32'd0);
        chk("r1Timeout", 32'(op_timeout), 32'd0);
        tick();
        chk("r1IterHold", 32'(op_iterCount), 32'd2);

        // Early convergence, limit 5
        startRun(8'd5);
        chk("r2IterClr", 32'(op_iterCount), 32'd0);
        phase("r2C", 3'b100, 3, 1'b0);
        gap("r2G1");
        phase("r2W", 3'b010, 3, 1'b0);
        gap("r2G2");
        phase("r2I", 3'b001, 3, 1'b1);
        chk("r2Done", 32'(op_done), 32'd1);
        chk("r2Iter", 32'(op_iterCount), 32'd1);
        tick();
        chk("r2Idle", 32'(op_busy), 32'd0);
        chk("r2NoCompute", 32'(en), 32'd0);
        tick();
        chk("r2NoCompute2", 32'(en), 32'd0);

        // Foreign dones, stray convergence and a mid-run start are ignored
        startRun(8'd2);
        chk("r3C", 32'(en), 32'd4);
        in_writeDone     = 1'b1;
        in_integrateDone = 1'b1;
        in_converged     = 1'b1;
        tick();
        in_writeDone     = 1'b0;
        in_integrateDone = 1'b0;
        in_converged     = 1'b0;
        chk("r3StillC", 32'(en), 32'd4);
        phase("r3C", 3'b100, 2, 1'b0);
        gap("r3G1");
        chk("r3W", 32'(en), 32'd2);
        in_start     = 1'b1;
        in_iterLimit = 8'd1;
        tick();
        in_start = 1'b0;
        phase("r3W", 3'b010, 2, 1'b0);
        gap("r3G2");
        phase("r3I1", 3'b001, 3, 1'b0);
        chk("r3NotDone", 32'(op_done), 32'd0);
        chk("r3Iter1", 32'(op_iterCount), 32'd1);
        gap("r3G3");
        phase("r3C2", 3'b100, 3, 1'b0);
        gap("r3G4");
        phase("r3W2", 3'b010, 3, 1'b0);
        gap("r3G5");
        phase("r3I2", 3'b001, 3, 1'b0);
        chk("r3Done", 32'(op_done), 32'd1);
        chk("r3Iter", 32'(op_iterCount), 32'd2);
        tick();

        // Write phase timeout
        startRun(8'd1);
        phase("r4C", 3'b100, 3, 1'b0);
        gap("r4G1");
        for (int i = 0; i < 16; i++) begin
            chk("r4WHold", 32'(en), 32'd2);
            tick();
        end
        chk("r4WFall", 32'(en), 32'd0);
        chk("r4Timeout", 32'(op_timeout), 32'd1);
        chk("r4Busy", 32'(op_busy), 32'd0);
        chk("r4NoDone", 32'(op_done), 32'd0);
        tick();
        chk("r4NoDone2", 32'(op_done), 32'd0);
        chk("r4Sticky", 32'(op_timeout), 32'd1);
        startRun(8'd1);
        chk("r5TimeoutClr", 32'(op_timeout), 32'd0);
        phase("r5C", 3'b100, 3, 1'b0);
        gap("r5G1");
        phase("r5W", 3'b010, 3, 1'b0);
        gap("r5G2");
        // Done arrives on the very cycle the wait counter expires
        phase("r5I", 3'b001, 16, 1'b0);
        chk("r5DoneWins", 32'(op_done), 32'd1);
        chk("r5NoTimeout", 32'(op_timeout), 32'd0);
        chk("r5Iter", 32'(op_iterCount), 32'd1);
        tick();

        // Async reset mid-integrate
        startRun(8'd3);
        phase("r6C", 3'b100, 3, 1'b0);
        gap("r6G1");
        phase("r6W", 3'b010, 3, 1'b0);
        gap("r6G2");
        chk("r6I", 32'(en), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("r6RstEn", 32'(en), 32'd0);
        chk("r6RstBusy", 32'(op_busy), 32'd0);
        chk("r6RstDone", 32'(op_done), 32'd0);
        chk("r6RstIter", 32'(op_iterCount), 32'd0);
        chk("r6RstTimeout", 32'(op_timeout), 32'd0);
        tick();
        reset = 1'b1;
        tick();
        chk("r6Idle", 32'(op_busy), 32'd0);
        tick();
        chk("r6IdleEn", 32'(en), 32'd0);
        startRun(8'd0);
        chk("r7C", 32'(en), 32'd4);
        chk("r7Iter", 32'(op_iterCount), 32'd0);
        chk("r7Busy", 32'(op_busy), 32'd1);
        phase("r7C", 3'b100, 3, 1'b0);
        gap("r7G1");
        phase("r7W", 3'b010, 3, 1'b0);
        gap("r7G2");
        phase("r7I", 3'b001, 3, 1'b0);
        chk("r7LimitZeroDone", 32'(op_done), 32'd1);
        chk("r7IterOne", 32'(op_iterCount), 32'd1);
        tick();
        chk("r7Idle", 32'(op_busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
